// File: rtl/rom_reader.sv
// -----------------------------------------------------------------------------
// rom_reader
//
// Purpose:
//   Walks an inclusive address range of a synchronous (registered-output) ROM
//   and presents each word on a valid/ready output. One word is read, captured
//   and held until the consumer accepts it before the next read is issued, so
//   the best-case rate is one word every three cycles. Ranges whose end lies
//   below their start wrap through the top of the address space.
//
// Ports:
//   clk         single clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   start       begin a range read (only looked at while idle)
//   first_addr  range start, captured with start
//   last_addr   range end (inclusive), captured with start
//   rom_en      ROM read enable (high only in the request state)
//   rom_addr    ROM read address (holds its last value when rom_en is low)
//   rom_data    ROM read data, valid one cycle after rom_en
//   out_data    captured word
//   out_valid   out_data holds a word not yet accepted
//   out_ready   consumer accepts; transfer = out_valid && out_ready at an edge
//   out_last    out_data is the final word of the range
//   busy        high whenever the reader is not idle
//   done        one-cycle pulse after the final transfer
//   checksum    8-bit running sum of transferred words (CHECKSUM_EN only)
//
// Build option:
//   CHECKSUM_EN  when defined, adds the checksum port and its accumulator.
// -----------------------------------------------------------------------------
module rom_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
`ifdef CHECKSUM_EN
    output logic [7:0]        checksum,
`endif
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CAP  = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cur_q;
    logic [ADDR_W-1:0]   end_q;
    logic [ADDR_W-1:0]   cur_d;
    logic                rom_en_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                busy_q;
    logic                done_q;
`ifdef CHECKSUM_EN
    logic [7:0]          checksum_q;
`endif

    // Next address; natural ADDR_W-bit overflow gives the wrap-around.
    assign cur_d = cur_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Reader state machine; every output is driven from a register here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= {ADDR_W{1'b0}};
            end_q       <= {ADDR_W{1'b0}};
            rom_en_q    <= 1'b0;
            rom_addr_q  <= {ADDR_W{1'b0}};
            out_data_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CHECKSUM_EN
            checksum_q  <= 8'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cur_q      <= first_addr;
                        end_q      <= last_addr;
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= first_addr;
                        busy_q     <= 1'b1;
`ifdef CHECKSUM_EN
                        checksum_q <= 8'd0;
`endif
                        state_q    <= S_REQ;
                    end else begin
                        state_q    <= S_IDLE;
                    end
                end
                S_REQ: begin
                    // ROM samples the request on this edge; data arrives in CAP.
                    rom_en_q <= 1'b0;
                    state_q  <= S_CAP;
                end
                S_CAP: begin
                    out_data_q  <= rom_data;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (cur_q == end_q);
                    state_q     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
`ifdef CHECKSUM_EN
                        checksum_q  <= checksum_q + 8'(out_data_q);
`endif
                        if (out_last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cur_q      <= cur_d;
                            rom_addr_q <= cur_d;
                            rom_en_q   <= 1'b1;
                            state_q    <= S_REQ;
                        end
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    rom_en_q    <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef CHECKSUM_EN
    assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_rom_reader.sv
// -----------------------------------------------------------------------------
// tb_rom_reader
//
// Purpose:
//   Self-checking bench for rom_reader (ADDR_W=4, DATA_W=4) with a registered
//   16x4 ROM holding mem[i] = ~i. Expected words, flags, address sequence and
//   checksum are computed from the range arithmetic, independent of the RTL.
//   The checksum port and its checks follow the CHECKSUM_EN build option.
// -----------------------------------------------------------------------------
module tb_rom_reader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] first_addr;
    logic [3:0] last_addr;
    logic       rom_en;
    logic [3:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;
`ifdef CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] addr_log[$];

    rom_reader #(.ADDR_W(4), .DATA_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
`ifdef CHECKSUM_EN
        .checksum   (checksum),
`endif
        .done       (done)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM model with mem[i] = ~i; also logs every read address.
    always @(posedge clk) begin
        if (rom_en) begin
            rom_data <= ~rom_addr;
            addr_log.push_back(rom_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reads range f..l and checks every word; mode 0 = always ready,
    // 1 = random ready, 2 = hold off the first word for 5 cycles.
    // poke pulses start with other addresses while the range is running.
    task automatic run_range(input logic [3:0] f, input logic [3:0] l,
                             input int mode, input bit poke);
        int         count;
        int         idx;
        int         lat;
        int         cyc;
        int         stall;
        bit         ready;
        bit         chk_resume;
        logic [3:0] exp_d;
        logic [3:0] a;
        logic [7:0] exp_sum;

        count = ((int'(l) - int'(f) + 16) % 16) + 1;
        exp_sum = 8'd0;
        for (int k = 0; k < count; k++) begin
            a = f + 4'(k);
            exp_sum = exp_sum + {4'd0, ~a};
        end

        addr_log.delete();
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        out_ready  = (mode == 0);
        @(negedge clk);
        start      = 1'b0;
        first_addr = 4'($urandom);
        last_addr  = 4'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);

        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("valid_latency", 32'(lat), 32'd2);

        idx = 0; cyc = 0; stall = 0; chk_resume = 1'b0;
        while (idx < count && cyc < 2000) begin
            start = 1'b0;
            if (poke && cyc == 3) begin
                start      = 1'b1;
                first_addr = f + 4'd5;
                last_addr  = f + 4'd6;
            end
            if (chk_resume) begin
                chk("resume_rom_en", 32'(rom_en), 32'd1);
                a = f + 4'd1;
                chk("resume_rom_addr", 32'(rom_addr), 32'(a));
                chk_resume = 1'b0;
            end
            if (out_valid) begin
                a = f + 4'(idx);
                exp_d = ~a;
                chk("out_data", 32'(out_data), 32'(exp_d));
                chk("out_last", 32'(out_last), 32'(idx == count - 1));
                chk("no_read_while_held", 32'(rom_en), 32'd0);
                case (mode)
                    0: ready = 1'b1;
                    1: ready = 1'($urandom_range(0, 1));
                    default: begin
                        ready = (idx != 0) || (stall >= 5);
                        if (!ready) stall++;
                        else if (idx == 0 && count > 1) chk_resume = 1'b1;
                    end
                endcase
                out_ready = ready;
                if (ready) idx++;
            end else begin
                out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : out_ready;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("word_count", 32'(idx), 32'(count));
        if (mode == 2) chk("stall_cycles", 32'(stall), 32'd5);

        chk("done_pulse", 32'(done), 32'd1);
        chk("valid_cleared", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_not_busy", 32'(busy), 32'd0);
`ifdef CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(exp_sum));
`endif
        chk("read_count", 32'(addr_log.size()), 32'(count));
        for (int k = 0; k < count && k < addr_log.size(); k++) begin
            a = f + 4'(k);
            chk("rom_addr_seq", 32'(addr_log[k]), 32'(a));
        end
        @(negedge clk);
        chk("stays_idle", 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rom_en"},    32'(rom_en),    32'd0);
        chk({tag, "_rom_addr"},  32'(rom_addr),  32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
`ifdef CHECKSUM_EN
        chk({tag, "_checksum"},  32'(checksum),  32'd0);
`endif
    endtask

    initial begin
        int lim;
        rst = 1'b1; start = 1'b1; first_addr = 4'd9; last_addr = 4'd3;
        out_ready = 1'b0; rom_data = 4'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        run_range(4'd2,  4'd4, 0, 1'b0);
        run_range(4'd14, 4'd1, 0, 1'b0);
        run_range(4'd7,  4'd7, 0, 1'b0);
        run_range(4'd3,  4'd6, 2, 1'b0);
        run_range(4'd5,  4'd10, 0, 1'b1);
        for (int r = 0; r < 6; r++)
            run_range(4'($urandom), 4'($urandom), 1, 1'b0);

        // Reset while a word is held, then a fresh single-word read.
        first_addr = 4'd0; last_addr = 4'd15; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lim = 0;
        while (!out_valid && lim < 10) begin
            @(negedge clk);
            lim++;
        end
        chk("hold_reached", 32'(out_valid), 32'd1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_stale_valid", 32'(out_valid), 32'd0);
        run_range(4'd0, 4'd0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
